regfile_sync_2r1w: RTL and testbench

Clocked, parametrised register file with two read ports and one write port, replacing the mode-multiplexed combinational register file in the datapath. Storage is initialised by a built-in clear sequencer after reset or on request, rather than by a parallel reset of every word. Reads are registered with write-to-read bypass, so a value written in cycle N is visible to a read issued in the same cycle N.

---
 rtl/regfile_sync_2r1w.sv | 173 +++++++++++++++++
 tb/tb_regfile_sync_2r1w.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sync_2r1w.sv
// regfile_sync_2r1w: clocked 2-read/1-write register file.
// Storage is zeroed by an internal clear sequencer (after reset or on Clear)
// instead of a parallel reset. Reads are registered and a write is bypassed
// to a read of the same address in the same cycle.
// Optional build macro: REGFILE_ZERO_REG_EN makes address 0 a hardwired zero.
module regfile_sync_2r1w #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Clear,
  input  logic              WriteEnable,
  input  logic [ADDR_W-1:0] WriteAddress,
  input  logic [DATA_W-1:0] WriteValue,
  input  logic [ADDR_W-1:0] ReadAddress1,
  input  logic [ADDR_W-1:0] ReadAddress2,
  output logic [DATA_W-1:0] ReadValue1,
  output logic [DATA_W-1:0] ReadValue2,
  output logic              Busy,
  output logic              WriteDropped
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_nx;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              waddr_ok;
  logic              wr_zero;
  logic              wr_accept;
  logic              wr_drop;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic [DATA_W-1:0] rd1_nx;
  logic [DATA_W-1:0] rd2_nx;

  // Busy is a direct decode of the state register, so it has no input path.
  assign busy = (state == CLEAR);
  assign Busy = busy;

  // Read-data selection: blocked while clearing, zero out of range,
  // bypass from an accepted same-cycle write, otherwise storage.
  function automatic logic [DATA_W-1:0] read_sel(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (busy || Clear) begin
      val = '0;
    end else if ({1'b0, addr} >= DEPTH_X) begin
      val = '0;
`ifdef REGFILE_ZERO_REG_EN
    end else if (addr == '0) begin
      val = '0;
`endif
    end else if (wr_accept && (WriteAddress == addr)) begin
      val = WriteValue;
    end else begin
      val = mem[addr];
    end
    return val;
  endfunction

  // Write qualification: accepted only in IDLE, without Clear, in range.
  always_comb begin
    waddr_ok = ({1'b0, WriteAddress} < DEPTH_X);
`ifdef REGFILE_ZERO_REG_EN
    wr_zero  = (WriteAddress == '0);
`else
    wr_zero  = 1'b0;
`endif
    wr_accept = WriteEnable && !busy && !Clear && waddr_ok && !wr_zero;
    wr_drop   = WriteEnable && (busy || Clear || !waddr_ok);
  end

  // Next-state logic for the clear sequencer.
  always_comb begin
    state_nx   = state;
    clr_ptr_nx = clr_ptr;
    case (state)
      CLEAR: begin
        if (Clear) begin
          clr_ptr_nx = '0;
        end else if (clr_ptr == LAST_ADDR) begin
          state_nx   = IDLE;
          clr_ptr_nx = '0;
        end else begin
          clr_ptr_nx = clr_ptr + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (Clear) begin
          state_nx   = CLEAR;
          clr_ptr_nx = '0;
        end
      end
      default: begin
        state_nx   = CLEAR;
        clr_ptr_nx = '0;
      end
    endcase
  end

  // Sequencer state register; reset restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= clr_ptr_nx;
    end
  end

  // Single storage write port shared by the clear sequencer and user writes.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (rst_n) begin
      if (busy) begin
        mem_we = 1'b1;
        mem_wa = clr_ptr;
        mem_wd = '0;
      end else if (wr_accept) begin
        mem_we = 1'b1;
        mem_wa = WriteAddress;
        mem_wd = WriteValue;
      end
    end
  end

  // Storage array; no reset, it is initialised by the clear sequencer.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Next read data for both ports.
  always_comb begin
    rd1_nx = read_sel(ReadAddress1);
    rd2_nx = read_sel(ReadAddress2);
  end

  // Registered read data and dropped-write pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ReadValue1   <= '0;
      ReadValue2   <= '0;
      WriteDropped <= 1'b0;
    end else begin
      ReadValue1   <= rd1_nx;
      ReadValue2   <= rd2_nx;
      WriteDropped <= wr_drop;
    end
  end

endmodule

// File: tb/tb_regfile_sync_2r1w.sv
// Testbench for regfile_sync_2r1w: two instances (DEPTH 32 and DEPTH 20)
// driven with the same stimulus and compared every cycle against a
// behavioural model, plus directed checks with fixed expected values.
module tb_regfile_sync_2r1w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wv;
  logic [4:0]  ra1;
  logic [4:0]  ra2;

  logic [31:0] rv1_a, rv2_a, rv1_b, rv2_b;
  logic        busy_a, busy_b, wd_a, wd_b;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  regfile_sync_2r1w u_dut (
    .clk(clk), .rst_n(rst_n), .Clear(clear), .WriteEnable(we),
    .WriteAddress(wa), .WriteValue(wv),
    .ReadAddress1(ra1), .ReadAddress2(ra2),
    .ReadValue1(rv1_a), .ReadValue2(rv2_a),
    .Busy(busy_a), .WriteDropped(wd_a)
  );

  regfile_sync_2r1w #(.DATA_W(32), .DEPTH(20), .ADDR_W(5)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .Clear(clear), .WriteEnable(we),
    .WriteAddress(wa), .WriteValue(wv),
    .ReadAddress1(ra1), .ReadAddress2(ra2),
    .ReadValue1(rv1_b), .ReadValue2(rv2_b),
    .Busy(busy_b), .WriteDropped(wd_b)
  );

  // Reference model: whole memory zeroed at once when a clear starts (it is
  // unobservable until the clear finishes), and a countdown of busy cycles.
  int unsigned dep [2] = '{32, 20};
  logic [31:0] mm  [2][32];
  int unsigned rem [2];
  logic [31:0] e_rv1 [2];
  logic [31:0] e_rv2 [2];
  logic        e_wd  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_read(int k, logic [4:0] a, logic bsy, logic acc);
    if (bsy || clear) return 32'h0;
    if (int'(a) >= int'(dep[k])) return 32'h0;
`ifdef REGFILE_ZERO_REG_EN
    if (a == 5'd0) return 32'h0;
`endif
    if (acc && wa == a) return wv;
    return mm[k][a];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic bsy, oor, acc;
      if (!rst_n) begin
        e_rv1[k] = '0;
        e_rv2[k] = '0;
        e_wd[k]  = 1'b0;
        rem[k]   = dep[k];
        for (int i = 0; i < 32; i++) mm[k][i] = '0;
      end else begin
        bsy = (rem[k] != 0);
        oor = (int'(wa) >= int'(dep[k]));
        acc = !bsy && !clear && we && !oor;
`ifdef REGFILE_ZERO_REG_EN
        if (wa == 5'd0) acc = 1'b0;
`endif
        e_wd[k]  = we && (bsy || clear || oor);
        e_rv1[k] = model_read(k, ra1, bsy, acc);
        e_rv2[k] = model_read(k, ra2, bsy, acc);
        if (acc) mm[k][wa] = wv;
        if (clear) begin
          rem[k] = dep[k];
          for (int i = 0; i < 32; i++) mm[k][i] = '0;
        end else if (bsy) begin
          rem[k] = rem[k] - 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("rv1_d32",  rv1_a, e_rv1[0]);
    check("rv2_d32",  rv2_a, e_rv2[0]);
    check("wd_d32",   {31'b0, wd_a},   {31'b0, e_wd[0]});
    check("busy_d32", {31'b0, busy_a}, {31'b0, rem[0] != 0});
    check("rv1_d20",  rv1_b, e_rv1[1]);
    check("rv2_d20",  rv2_b, e_rv2[1]);
    check("wd_d20",   {31'b0, wd_b},   {31'b0, e_wd[1]});
    check("busy_d20", {31'b0, busy_b}, {31'b0, rem[1] != 0});
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while ((busy_a || busy_b) && n < 40) begin
      step();
      n++;
    end
    check("idle_timeout", {31'b0, busy_a | busy_b}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; we = 1'b0;
    wa = '0; wv = '0; ra1 = '0; ra2 = '0;

    // Reset for two cycles, then the 32-cycle clear.
    step();
    step();
    check("rst_rv1", rv1_a, 32'h0);
    check("rst_busy", {31'b0, busy_a}, 32'h1);
    rst_n = 1'b1;
    for (int i = 0; i < 31; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      step();
    end
    check("busy_31", {31'b0, busy_a}, 32'h1);
    step();
    check("busy_32", {31'b0, busy_a}, 32'h0);

    // Write then read back on the next cycle.
    we = 1'b1; wa = 5'd7; wv = 32'hDEADBEEF; ra1 = 5'd0; ra2 = 5'd0;
    step();
    we = 1'b0; ra1 = 5'd7; ra2 = 5'd8;
    step();
    check("wr_rb_p1", rv1_a, 32'hDEADBEEF);
    check("wr_rb_p2", rv2_a, 32'h0);

    // Same-cycle bypass on both ports.
    we = 1'b1; wa = 5'd3; wv = 32'h12345678; ra1 = 5'd3; ra2 = 5'd3;
    step();
    check("byp_p1", rv1_a, 32'h12345678);
    check("byp_p2", rv2_a, 32'h12345678);

    // Write during clear is dropped and the word reads as zero afterwards.
    we = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    we = 1'b1; wa = 5'd4; wv = 32'hA5A5A5A5;
    step();
    check("clr_wd", {31'b0, wd_a}, 32'h1);
    we = 1'b0;
    wait_idle();
    ra1 = 5'd4;
    step();
    check("clr_rd4", rv1_a, 32'h0);

    // Address 0 write: bypass and stored readback.
    we = 1'b1; wa = 5'd0; wv = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
    step();
`ifdef REGFILE_ZERO_REG_EN
    check("zr_byp", rv1_a, 32'h0);
`else
    check("zr_byp", rv1_a, 32'hFFFFFFFF);
`endif
    we = 1'b0;
    step();
`ifdef REGFILE_ZERO_REG_EN
    check("zr_rd", rv1_a, 32'h0);
`else
    check("zr_rd", rv1_a, 32'hFFFFFFFF);
`endif

    // Out-of-range write on the DEPTH=20 instance.
    we = 1'b1; wa = 5'd25; wv = 32'h1; ra1 = 5'd25;
    step();
    check("oor_wd", {31'b0, wd_b}, 32'h1);
    check("oor_rd", rv1_b, 32'h0);
    we = 1'b0;
    step();
    check("oor_rd2", rv1_b, 32'h0);

    // Randomised traffic with occasional Clear and reset.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      clear = ($urandom_range(0, 79) == 0);
      we    = ($urandom_range(0, 2) != 0);
      wa    = 5'($urandom_range(0, 31));
      wv    = $urandom;
      ra1   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2   = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
